// File: rtl/hgcal_input_stager_if.sv
// Sample-in / event-out handshake bundle for the HGCAL input stager.
// slave = the stager's view, master = the producer/consumer environment.
interface hgcal_input_stager_if #(
  parameter int NUM_CH = 48,
  parameter int IN_W   = 8,
  parameter int Q_BITS = 2
);
  logic                     s_valid;
  logic                     s_ready;
  logic [IN_W-1:0]          s_data;
  logic                     s_last;
  logic                     m_valid;
  logic                     m_ready;
  logic [NUM_CH*Q_BITS-1:0] m_data;
  logic                     m_err;

  modport slave (
    input  s_valid, s_data, s_last, m_ready,
    output s_ready, m_valid, m_data, m_err
  );

  modport master (
    output s_valid, s_data, s_last, m_ready,
    input  s_ready, m_valid, m_data, m_err
  );
endinterface

// File: rtl/hgcal_input_stager.sv
// Quantizes raw cell samples and packs NUM_CH of them into a registered event
// vector; a fill buffer plus output register lets event N+1 stream in while N is held.
module hgcal_input_stager #(
  parameter int NUM_CH = 48,
  parameter int IN_W   = 8,
  parameter int Q_BITS = 2,
  parameter int SHIFT  = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  hgcal_input_stager_if.slave  bus,
  output logic                 dbg_full_o
);
  // Both channels use valid/ready: a transfer happens on the rising edge where
  // valid && ready; the sender holds data stable until then, ready never waits on valid.
  localparam int DW = NUM_CH * Q_BITS;
  localparam int CW = $clog2(NUM_CH + 1);
  localparam logic [IN_W-1:0] QMAX = IN_W'((1 << Q_BITS) - 1);

  typedef enum logic [0:0] {ST_FILL, ST_FULL} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   ch_cnt_q, ch_cnt_d;
  logic [DW-1:0]   fill_q, fill_d;
  logic            err_pend_q, err_pend_d;
  logic            out_valid_q, out_valid_d;
  logic [DW-1:0]   out_data_q, out_data_d;
  logic            out_err_q, out_err_d;

  logic [IN_W-1:0]   shifted;
  logic [Q_BITS-1:0] q;
  logic              s_ready;
  logic              accept;
  logic              last_cell;
  logic              complete;
  logic              evt_err;
  logic              out_free;
  logic [DW-1:0]     evt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_FILL;
      ch_cnt_q    <= '0;
      fill_q      <= '0;
      err_pend_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      ch_cnt_q    <= ch_cnt_d;
      fill_q      <= fill_d;
      err_pend_q  <= err_pend_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_err_q   <= out_err_d;
    end
  end

  always_comb begin
    shifted   = bus.s_data >> SHIFT;
    q         = (shifted > QMAX) ? Q_BITS'(QMAX) : shifted[Q_BITS-1:0];
    s_ready   = !rst && (state_q == ST_FILL);
    accept    = bus.s_valid && s_ready;
    last_cell = (ch_cnt_q == CW'(NUM_CH - 1));
    complete  = accept && (bus.s_last || last_cell);
    // Only an s_last landing exactly on the final cell is a well-formed event.
    evt_err   = !(bus.s_last && last_cell);
    out_free  = !out_valid_q || bus.m_ready;

    evt = fill_q;
    for (int k = 0; k < NUM_CH; k++) begin
      if (CW'(k) == ch_cnt_q) evt[k*Q_BITS +: Q_BITS] = q;
    end

    state_d     = state_q;
    ch_cnt_d    = ch_cnt_q;
    fill_d      = fill_q;
    err_pend_d  = err_pend_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_err_d   = out_err_q;

    if (out_valid_q && bus.m_ready) out_valid_d = 1'b0;

    case (state_q)
      ST_FILL: begin
        if (complete) begin
          ch_cnt_d = '0;
          if (out_free) begin
            // Bypass: the finished event goes straight to the output register.
            out_valid_d = 1'b1;
            out_data_d  = evt;
            out_err_d   = evt_err;
            fill_d      = '0;
            err_pend_d  = 1'b0;
          end else begin
            state_d    = ST_FULL;
            fill_d     = evt;
            err_pend_d = evt_err;
          end
        end else if (accept) begin
          ch_cnt_d = ch_cnt_q + CW'(1);
          fill_d   = evt;
        end
      end
      ST_FULL: begin
        if (out_free) begin
          out_valid_d = 1'b1;
          out_data_d  = fill_q;
          out_err_d   = err_pend_q;
          fill_d      = '0;
          err_pend_d  = 1'b0;
          state_d     = ST_FILL;
        end
      end
      default: state_d = ST_FILL;
    endcase
  end

  assign bus.s_ready = s_ready;
  assign bus.m_valid = out_valid_q;
  assign bus.m_data  = out_data_q;
  assign bus.m_err   = out_err_q;
  assign dbg_full_o  = (state_q == ST_FULL);
endmodule

// File: tb/tb_hgcal_input_stager.sv
// Bench for hgcal_input_stager: directed and random events checked against
// an event-level reference model (raw sample lists -> packed expected events).
module tb_hgcal_input_stager;
  localparam int NUM_CH = 48;
  localparam int IN_W   = 8;
  localparam int Q_BITS = 2;
  localparam int SHIFT  = 5;
  localparam int DW     = NUM_CH * Q_BITS;

  logic clk = 1'b0;
  logic rst;
  logic dbg_full;
  logic rand_en, rand_ready, dir_ready;

  always #5 clk = ~clk;

  hgcal_input_stager_if #(.NUM_CH(NUM_CH), .IN_W(IN_W), .Q_BITS(Q_BITS)) bus ();

  hgcal_input_stager #(.NUM_CH(NUM_CH), .IN_W(IN_W), .Q_BITS(Q_BITS), .SHIFT(SHIFT)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus.slave),
    .dbg_full_o (dbg_full)
  );

  assign bus.m_ready = rand_en ? rand_ready : dir_ready;

  // m_ready only moves 2 time units after a rising edge, away from the sampling edge.
  always @(posedge clk) begin
    #2;
    rand_ready = 1'($urandom_range(0, 1));
  end

  int total = 0;
  int bad = 0;
  int hs_cnt = 0;
  int stall_cnt = 0;
  logic [DW:0] exp_q[$];
  int cur_raw[$];

  task automatic chk(input string tag, input logic [DW:0] obs, input logic [DW:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [Q_BITS-1:0] quant(input int raw);
    int v;
    v = raw / (1 << SHIFT);
    if (v > (1 << Q_BITS) - 1) v = (1 << Q_BITS) - 1;
    return Q_BITS'(v);
  endfunction

  function automatic void model_accept(input int raw, input logic last);
    logic [DW-1:0] d;
    d = '0;
    cur_raw.push_back(raw);
    if (last || cur_raw.size() == NUM_CH) begin
      for (int k = 0; k < cur_raw.size(); k++) d[k*Q_BITS +: Q_BITS] = quant(cur_raw[k]);
      exp_q.push_back({!(last && cur_raw.size() == NUM_CH), d});
      cur_raw.delete();
    end
  endfunction

  // Scoreboard: every consumed event must match the model; held events must not move.
  logic prev_hold = 1'b0;
  logic [DW:0] prev_out;
  always @(negedge clk) begin
    if (rst) begin
      prev_hold = 1'b0;
    end else begin
      if (prev_hold) begin
        chk("hold_valid", bus.m_valid, 1);
        chk("hold_data", {bus.m_err, bus.m_data}, prev_out);
      end
      if (bus.m_valid && bus.m_ready) begin
        if (exp_q.size() == 0) chk("unexpected_event", {bus.m_err, bus.m_data}, '1);
        else begin
          chk("event", {bus.m_err, bus.m_data}, exp_q.pop_front());
          hs_cnt++;
        end
      end
      prev_hold = bus.m_valid && !bus.m_ready;
      prev_out  = {bus.m_err, bus.m_data};
    end
  end

  task automatic do_reset();
    rst = 1'b1;
    bus.s_valid = 1'b0;
    bus.s_last  = 1'b0;
    exp_q.delete();
    cur_raw.delete();
    @(negedge clk);
    chk("rst_s_ready", bus.s_ready, 0);
    chk("rst_m_valid", bus.m_valid, 0);
    chk("rst_m_data", bus.m_data, 0);
    chk("rst_m_err", bus.m_err, 0);
    rst = 1'b0;
    #1;
    chk("post_rst_s_ready", bus.s_ready, 1);
  endtask

  task automatic send(input int raw, input logic last);
    int w;
    w = 0;
    bus.s_valid = 1'b1;
    bus.s_data  = IN_W'(raw);
    bus.s_last  = last;
    while (!bus.s_ready && w < 300) begin
      @(negedge clk);
      w++;
    end
    stall_cnt += w;
    if (w >= 300) begin
      chk("s_ready_timeout", bus.s_ready, 1);
    end else begin
      model_accept(raw, last);
      @(negedge clk);
    end
    bus.s_valid = 1'b0;
    bus.s_last  = 1'b0;
  endtask

  task automatic set_ready(input logic en, input logic v);
    @(posedge clk);
    #2;
    rand_en   = en;
    dir_ready = v;
    @(negedge clk);
  endtask

  initial begin
    logic [DW-1:0] e;
    logic [DW:0] exp_a, exp_b;
    int hs0, len;
    rst = 1'b1;
    rand_en = 1'b0;
    dir_ready = 1'b1;
    bus.s_valid = 1'b0;
    bus.s_data = '0;
    bus.s_last = 1'b0;
    do_reset();

    // Ramp event: raw[k] = 5k, exact length.
    for (int k = 0; k < NUM_CH - 1; k++) send(k * 5, 1'b0);
    chk("t1_valid_before_last", bus.m_valid, 0);
    send(235, 1'b1);
    chk("t1_valid", bus.m_valid, 1);
    chk("t1_cell0", bus.m_data[1:0], 0);
    chk("t1_cell7", bus.m_data[15:14], 1);
    chk("t1_cell13", bus.m_data[27:26], 2);
    chk("t1_cell20", bus.m_data[41:40], 3);
    chk("t1_cell47", bus.m_data[95:94], 3);
    chk("t1_err", bus.m_err, 0);

    // Short event: 10 saturating samples.
    for (int k = 0; k < 10; k++) send(200, k == 9);
    e = '0;
    e[19:0] = '1;
    chk("t2_data", bus.m_data, e);
    chk("t2_err", bus.m_err, 1);

    // Overlong event: 48 + 2 samples, then close the second event.
    for (int k = 0; k < NUM_CH; k++) send(64, 1'b0);
    e = {NUM_CH{2'b10}};
    chk("t3_data", bus.m_data, e);
    chk("t3_err", bus.m_err, 1);
    send(64, 1'b0);
    send(64, 1'b0);
    chk("t3_valid_drop", bus.m_valid, 0);
    send(64, 1'b1);
    chk("t3_next_data", bus.m_data, 96'h2A);
    chk("t3_next_err", bus.m_err, 1);

    // Backpressure: two events with the consumer stalled.
    set_ready(1'b0, 1'b0);
    for (int k = 0; k < NUM_CH; k++) send($urandom_range(0, 255), k == NUM_CH - 1);
    for (int k = 0; k < NUM_CH; k++) send($urandom_range(0, 255), k == NUM_CH - 1);
    exp_a = exp_q[0];
    exp_b = exp_q[1];
    chk("t4_s_ready_full", bus.s_ready, 0);
    chk("t4_dbg_full", dbg_full, 1);
    chk("t4_held_a", {bus.m_err, bus.m_data}, exp_a);
    repeat (3) @(negedge clk);
    chk("t4_still_full", bus.s_ready, 0);
    set_ready(1'b0, 1'b1);
    @(negedge clk);
    chk("t4_b_out", {bus.m_err, bus.m_data}, exp_b);
    chk("t4_b_valid", bus.m_valid, 1);
    chk("t4_s_ready_back", bus.s_ready, 1);
    @(negedge clk);

    // Zero-bubble: three exact events streamed back to back.
    stall_cnt = 0;
    hs0 = hs_cnt;
    for (int k = 0; k < 3 * NUM_CH; k++) send($urandom_range(0, 255), (k % NUM_CH) == NUM_CH - 1);
    @(negedge clk);
    chk("t5_stalls", stall_cnt, 0);
    chk("t5_events", hs_cnt - hs0, 3);
    chk("t5_valid_idle", bus.m_valid, 0);

    // Reset mid-event, then a clean event with an ignored idle s_last.
    for (int k = 0; k < 20; k++) send($urandom_range(0, 255), 1'b0);
    do_reset();
    chk("t6_valid", bus.m_valid, 0);
    for (int k = 0; k < NUM_CH; k++) begin
      if (k == 10) begin
        bus.s_last = 1'b1;
        repeat (2) @(negedge clk);
        bus.s_last = 1'b0;
      end
      send($urandom_range(0, 255), k == NUM_CH - 1);
    end

    // Random lengths under random consumer backpressure.
    set_ready(1'b1, 1'b1);
    for (int ev = 0; ev < 8; ev++) begin
      len = $urandom_range(1, 52);
      for (int k = 0; k < len; k++) send($urandom_range(0, 255), k == len - 1);
    end
    set_ready(1'b0, 1'b1);
    repeat (4) @(negedge clk);
    chk("drain_empty", exp_q.size(), 0);
    chk("drain_partial", cur_raw.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
